// File: rtl/mux_arb_nto1.sv
// N-input registered mux/arbiter with valid/ready handshakes, explicit or round-robin select.
// Optional per-input saturating grant counters when MUX_ARB_GRANT_CNT_EN is defined.
module mux_arb_nto1 #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    localparam int unsigned SEL_W = $clog2(NUM_IN)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_IN*WIDTH-1:0]   in_data_i,
    input  logic [NUM_IN-1:0]         in_valid_i,
    output logic [NUM_IN-1:0]         in_ready_o,
    input  logic                      mode_i,
    input  logic [SEL_W-1:0]          sel_i,
    output logic [WIDTH-1:0]          out_data_o,
    output logic                      out_valid_o,
    output logic [SEL_W-1:0]          out_src_o,
    input  logic                      out_ready_i
`ifdef MUX_ARB_GRANT_CNT_EN
    ,
    output logic [NUM_IN*16-1:0]      grant_cnt_o
`endif
);

    logic [WIDTH-1:0] in_word [NUM_IN];
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             can_accept;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic             take;
    int unsigned      rr_idx;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
        assign in_word[g] = in_data_i[g*WIDTH +: WIDTH];
    end

    assign can_accept = !out_valid_q || out_ready_i;

    // Round-robin searches ptr+1, ptr+2, ... so the most recent winner has lowest priority.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_idx  = 0;
        if (!mode_i) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (sel_i == SEL_W'(i) && in_valid_i[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int unsigned k = 1; k <= NUM_IN; k++) begin
                rr_idx = int'(ptr_q) + k;
                if (rr_idx >= NUM_IN) rr_idx = rr_idx - NUM_IN;
                if (!gnt_vld && in_valid_i[rr_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(rr_idx);
                end
            end
        end
    end

    always_comb begin
        in_ready_o = '0;
        if (rst_ni && can_accept && gnt_vld) in_ready_o[gnt_idx] = 1'b1;
    end

    assign take = |(in_valid_i & in_ready_o);

    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (take) begin
            out_data_d  = in_word[gnt_idx];
            out_src_d   = gnt_idx;
            out_valid_d = 1'b1;
            ptr_d       = gnt_idx;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SEL_W'(NUM_IN - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_src_o   = out_src_q;
    assign out_valid_o = out_valid_q;

`ifdef MUX_ARB_GRANT_CNT_EN
    logic [15:0] cnt_q [NUM_IN];

    for (genvar g = 0; g < NUM_IN; g++) begin : g_cnt
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q[g] <= '0;
            end else if (take && gnt_idx == SEL_W'(g) && cnt_q[g] != 16'hFFFF) begin
                cnt_q[g] <= cnt_q[g] + 16'd1;
            end
        end
        assign grant_cnt_o[g*16 +: 16] = cnt_q[g];
    end
`endif

endmodule

// File: doc/mux_arb_nto1.md
Name: mux_arb_nto1

Overview:
- Parametrised N-input, W-bit registered multiplexer with per-input valid/ready handshakes and a single registered output stage.
- Used in the datapath wherever several producers share one consumer, such as write-back source select or memory-request merge.
- Two select modes:
  - Explicit: an external sel chooses the input, as with the combinational muxes.
  - Round-robin: internal fair arbitration across all valid inputs.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of inputs; legal range 2..16.
- SEL_W, $clog2(NUM_IN), derived localparam; width of sel and out_src. Not overridable.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous, active-low reset.
- in_data  input  NUM_IN*WIDTH  packed inputs; input i occupies [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-input valid.
- in_ready  output  NUM_IN  per-input ready; combinational.
- mode  input  1  0 = explicit sel, 1 = round-robin.
- sel  input  SEL_W  input index used when mode = 0.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_src  output  SEL_W  index of the input that supplied out_data.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (Rst_n low, asynchronous):
  - out_valid = 0, out_data = 0, out_src = 0.
  - Round-robin pointer ptr = NUM_IN-1, so input 0 has first priority.
- can_accept = !out_valid || out_ready.
- Grant (combinational):
  - mode 0: grant = sel when sel < NUM_IN and in_valid[sel] = 1; otherwise no grant.
  - mode 1: grant = first i with in_valid[i] = 1, searching ptr+1, ptr+2, ... modulo NUM_IN. No grant if all in_valid are 0.
- in_ready[i] = can_accept && (grant exists) && (grant == i). At most one bit of in_ready is set. All in_ready are 0 while Rst_n is low.
- Transfer in: when in_valid[g] && in_ready[g] at a rising edge:
  - out_data <= in_data[g], out_src <= g, out_valid <= 1.
  - ptr <= g, in both modes.
- Transfer out: out_valid && out_ready. If no transfer in occurs in the same cycle, out_valid <= 0; out_data and out_src keep their values.
- Simultaneous in and out in the same cycle: the output register is reloaded and out_valid stays 1. Full throughput is 1 word/cycle.
- Stall: while out_valid && !out_ready, out_data and out_src are held stable, and in_ready is all 0.
- Latency: 1 cycle from input handshake to out_valid.
- ptr changes only on an accepted transfer. Idle cycles and mode-0 traffic that does not reach the output do not move it.
- Mode or sel change: takes effect in the next grant evaluation. An already-registered output is unaffected.
- sel >= NUM_IN (NUM_IN not a power of 2): no grant, nothing accepted.
- Reset asserted mid-transfer: the registered word is discarded, out_valid drops immediately, and no handshake completes in that cycle.

Optional Feature:
- Macro: MUX_ARB_GRANT_CNT_EN.
- When defined:
  - Adds output grant_cnt, width NUM_IN*16: one 16-bit counter per input, in the same packing as in_data.
  - Counter i increments on each accepted transfer from input i and saturates at 16'hFFFF.
  - Counters clear on reset only.
- When undefined: the port and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, all in_valid = 0, out_ready = 1 -> out_valid = 0, out_data = 0, in_ready = 4'b0000 for 10 cycles.
- mode = 0, sel = 2, in_valid = 4'b1111, in_data[2] = 32'hDEADBEEF, out_ready = 1 -> in_ready = 4'b0100; next cycle out_data = 32'hDEADBEEF, out_src = 2, out_valid = 1.
- mode = 1, in_valid = 4'b1111 held, out_ready = 1 -> out_src sequence 0,1,2,3,0,1 on consecutive cycles, out_valid continuously 1.
- mode = 1, in_valid = 4'b1010, out_ready = 1 -> out_src alternates 1,3,1,3; in_ready[0] and in_ready[2] never set.
- Backpressure: out_valid = 1 with out_data = 32'h00000011, out_ready = 0 for 5 cycles -> out_data and out_src held, in_ready = 0. Raise out_ready -> the next word loads in the same cycle, no bubble.
- Pulse Rst_n low mid-stream with out_valid = 1 -> out_valid = 0 immediately. After release, the first round-robin grant goes to input 0. With MUX_ARB_GRANT_CNT_EN defined, all grant_cnt = 0 after reset.
